// File: rtl/fetch_unit.sv
// Fetch stage of the five-stage pipeline: owns the fetch PC, the F/D pipeline
// register, and the next-PC selection driven by the branch/jump decoded in D.
// The instruction at PC_F while a control transfer sits in D is its delay slot.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [31:0] Instr_F,
    input  logic [1:0]  NPCOp,
    input  logic        Branch,
    input  logic [31:0] RsFwd_D,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic        ExcAdEL_D
);

    // One past the last legal fetch address, kept 33 bits wide so a memory
    // that ends exactly at 2^32 does not wrap to zero.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JREG   = 2'b11;

    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        exc_d;

    logic [31:0] pc_f_plus4;
    logic [31:0] pc_d_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        fetch_exc;

    assign PC_F      = pc_f;
    assign Instr_D   = instr_d;
    assign PC_D      = pc_d;
    assign ExcAdEL_D = exc_d;

    // Link value for jal/jalr skips the delay slot; plain modulo-2^32 add.
    assign PC8_D = pc_d + 32'd8;

    // Candidate targets, all wrapping arithmetic; jumps take their region
    // bits from the delay-slot address, not from the jump itself.
    always_comb begin
        pc_f_plus4  = pc_f + 32'd4;
        pc_d_plus4  = pc_d + 32'd4;
        br_offset   = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
        br_target   = pc_d_plus4 + br_offset;
        jump_target = {pc_d_plus4[31:28], instr_d[25:0], 2'b00};
    end

    // Next-PC select; Branch only matters for the conditional-branch encoding
    // and jr targets pass through untouched so misalignment shows up on fetch.
    always_comb begin
        next_pc = pc_f_plus4;
        case (NPCOp)
            NPC_SEQ:    next_pc = pc_f_plus4;
            NPC_BRANCH: next_pc = Branch ? br_target : pc_f_plus4;
            NPC_JUMP:   next_pc = jump_target;
            NPC_JREG:   next_pc = RsFwd_D;
            default:    next_pc = pc_f_plus4;
        endcase
    end

    // A fetch is bad if unaligned or outside the instruction memory window.
    always_comb begin
        fetch_exc = (pc_f[1:0] != 2'b00)
                  || (pc_f < IM_BASE)
                  || ({1'b0, pc_f} >= IM_LIMIT);
    end

    // PC and F/D register update; reset beats stall, stall freezes everything
    // and the redirect is simply re-evaluated on the next free cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f    <= PC_RESET;
            instr_d <= 32'h0;
            pc_d    <= 32'h0;
            exc_d   <= 1'b0;
        end else if (!Stall) begin
            pc_f    <= next_pc;
            instr_d <= fetch_exc ? 32'h0 : Instr_F;
            pc_d    <= pc_f;
            exc_d   <= fetch_exc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: walks a hand-built instruction stream through
// sequential fetch, branches, jumps, jr, stalls, address faults and resets.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic [31:0] Instr_F;
    logic [1:0]  NPCOp;
    logic        Branch;
    logic [31:0] RsFwd_D;
    logic [31:0] PC_F;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
    logic        ExcAdEL_D;

    int total;
    int bad;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .Stall     (Stall),
        .Instr_F   (Instr_F),
        .NPCOp     (NPCOp),
        .Branch    (Branch),
        .RsFwd_D   (RsFwd_D),
        .PC_F      (PC_F),
        .Instr_D   (Instr_D),
        .PC_D      (PC_D),
        .PC8_D     (PC8_D),
        .ExcAdEL_D (ExcAdEL_D)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's inputs on the falling edge, then sample just after
    // the following rising edge.
    task automatic applyStimulus(input logic rst, input logic stl,
                                 input logic [1:0] op, input logic br,
                                 input logic [31:0] rs, input logic [31:0] instr);
        @(negedge clk);
        reset   = rst;
        Stall   = stl;
        NPCOp   = op;
        Branch  = br;
        RsFwd_D = rs;
        Instr_F = instr;
        @(posedge clk);
        #1;
    endtask

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    // Shorthand for the four architectural outputs after a step.
    task automatic checkState(input string tag, input logic [31:0] pcf,
                              input logic [31:0] pcd, input logic [31:0] instrd,
                              input logic exc);
        checkOutput({tag, ".PC_F"}, PC_F, pcf);
        checkOutput({tag, ".PC_D"}, PC_D, pcd);
        checkOutput({tag, ".Instr_D"}, Instr_D, instrd);
        checkOutput({tag, ".Exc"}, {31'b0, ExcAdEL_D}, {31'b0, exc});
    endtask

    // Directed sequence; expected values worked out by hand from the
    // next-PC rules and the 0x3000..0x6FFC legal fetch window.
    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        Stall   = 1'b0;
        NPCOp   = 2'b00;
        Branch  = 1'b0;
        RsFwd_D = 32'h0;
        Instr_F = 32'h0;

        // Reset state and sequential fetch, PC_D trailing by one edge.
        applyStimulus(1, 0, 2'b00, 0, 32'h0, 32'h0);
        checkState("rst", 32'h3000, 32'h0, 32'h0, 0);
        checkOutput("rst.PC8_D", PC8_D, 32'h8);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'hA000_0000);
        checkState("seq1", 32'h3004, 32'h3000, 32'hA000_0000, 0);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'hA000_0001);
        checkState("seq2", 32'h3008, 32'h3004, 32'hA000_0001, 0);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'hA000_0002);
        checkState("seq3", 32'h300C, 32'h3008, 32'hA000_0002, 0);

        // Taken backward branch: PC_D=3004, offset -8 from 3008 -> 3000.
        applyStimulus(1, 0, 2'b00, 0, 32'h0, 32'hA000_0003);
        checkState("rst2", 32'h3000, 32'h0, 32'h0, 0);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'hA000_0000);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h1000_FFFE);
        checkState("brload", 32'h3008, 32'h3004, 32'h1000_FFFE, 0);
        applyStimulus(0, 0, 2'b01, 1, 32'h0, 32'hA000_0001);
        checkState("brtaken", 32'h3000, 32'h3008, 32'hA000_0001, 0);
        checkOutput("brtaken.PC8_D", PC8_D, 32'h3010);

        // Not-taken branch falls through to PC_F+4.
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'hA000_0000);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h1000_0004);
        applyStimulus(0, 0, 2'b01, 0, 32'h0, 32'h1000_0004);
        checkState("brnot", 32'h300C, 32'h3008, 32'h1000_0004, 0);

        // Two stalled edges with a taken branch pending: nothing moves.
        applyStimulus(0, 1, 2'b01, 1, 32'h0, 32'hBADB_AD00);
        checkState("stall1", 32'h300C, 32'h3008, 32'h1000_0004, 0);
        applyStimulus(0, 1, 2'b01, 1, 32'h0, 32'hBADB_AD01);
        checkState("stall2", 32'h300C, 32'h3008, 32'h1000_0004, 0);
        // Released: 3008+4+16 = 301C.
        applyStimulus(0, 0, 2'b01, 1, 32'h0, 32'hA000_0003);
        checkState("unstall", 32'h301C, 32'h300C, 32'hA000_0003, 0);

        // Jump to word 0x0C00 in region 0 -> 0x3000; Branch=1 must not matter.
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0800_0C00);
        checkState("jload", 32'h3020, 32'h301C, 32'h0800_0C00, 0);
        checkOutput("jload.PC8_D", PC8_D, 32'h3024);
        applyStimulus(0, 0, 2'b10, 1, 32'h0, 32'hA000_0004);
        checkState("jump", 32'h3000, 32'h3020, 32'hA000_0004, 0);

        // jr to a misaligned target: taken as-is, faults on the next edge.
        applyStimulus(0, 0, 2'b11, 0, 32'h3002, 32'hA000_0005);
        checkState("jr", 32'h3002, 32'h3000, 32'hA000_0005, 0);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'hA000_0006);
        checkState("misal", 32'h3006, 32'h3002, 32'h0, 1);

        // Window edges: last legal word, first word past the end, below base.
        applyStimulus(0, 0, 2'b11, 0, 32'h6FFC, 32'hA000_0007);
        checkState("misal2", 32'h6FFC, 32'h3006, 32'h0, 1);
        applyStimulus(0, 0, 2'b11, 0, 32'h7000, 32'hA000_0008);
        checkState("lastok", 32'h7000, 32'h6FFC, 32'hA000_0008, 0);
        applyStimulus(0, 0, 2'b11, 0, 32'h2FFC, 32'hA000_0009);
        checkState("pastend", 32'h2FFC, 32'h7000, 32'h0, 1);
        applyStimulus(0, 0, 2'b11, 0, 32'hFFFF_FFFC, 32'hA000_000A);
        checkState("lowbase", 32'hFFFF_FFFC, 32'h2FFC, 32'h0, 1);

        // PC wrap-around and link value wrap.
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'hA000_000B);
        checkState("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1);
        checkOutput("wrap.PC8_D", PC8_D, 32'h4);

        // Jump keeps the upper region bits of the delay-slot address.
        applyStimulus(0, 0, 2'b11, 0, 32'hF000_0000, 32'hA000_000C);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0800_0010);
        checkState("hiload", 32'hF000_0004, 32'hF000_0000, 32'h0, 1);
        applyStimulus(0, 0, 2'b10, 0, 32'h0, 32'hA000_000D);
        checkState("hijump", 32'hF000_0000, 32'hF000_0004, 32'h0, 1);

        // Reset while stalled with a jump in D wins outright.
        applyStimulus(0, 0, 2'b11, 0, 32'h3100, 32'hA000_000E);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0800_0C40);
        checkState("jpend", 32'h3104, 32'h3100, 32'h0800_0C40, 0);
        applyStimulus(1, 1, 2'b10, 0, 32'h0, 32'hA000_000F);
        checkState("rststall", 32'h3000, 32'h0, 32'h0, 0);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'hB000_0000);
        checkState("postrst", 32'h3004, 32'h3000, 32'hB000_0000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
